// File: rtl/fib_cac_pkg.sv
// Shared types and constants for the Fibonacci (CAC) codeword decoder.
// Holds the controller state encoding, default widths and the weight-init value.
package fib_cac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned CW_WIDTH_DEF   = 8;
    localparam int unsigned DATA_WIDTH_DEF = 6;

    // Both weight registers start here, so the first advance yields w(1)=2.
    localparam int unsigned W_INIT = 1;

endpackage

// File: rtl/fib_step.sv
// One bit-serial Fibonacci decode step: weight advance, conditional add, adjacency check.
// Purely combinational so it can be chained for an unrolled decoder.
module fib_step
    import fib_cac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  bit_k,
    input  logic                  bit_prev,
    input  logic [DATA_WIDTH:0]   w_cur,
    input  logic [DATA_WIDTH:0]   w_prev,
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic                  err,
    output logic [DATA_WIDTH:0]   w_cur_nx,
    output logic [DATA_WIDTH:0]   w_prev_nx,
    output logic [DATA_WIDTH-1:0] acc_nx,
    output logic                  err_nx
);

    logic violation;

    always_comb begin
        w_prev_nx = w_cur;
        w_cur_nx  = w_cur + w_prev;
        violation = bit_k & bit_prev;
        err_nx    = err | violation;
        acc_nx    = acc;
        // Once an error is seen the sum freezes; the offending bit is never added.
        if (bit_k && !err && !violation) begin
            acc_nx = acc + DATA_WIDTH'(w_cur);
        end
    end

endmodule

// File: rtl/fib_decode_ctrl.sv
// Bit-serial Fibonacci (CAC) codeword decoder with valid/ready handshakes.
// IDLE accepts a codeword, RUN walks one bit per cycle, DONE holds the result.
module fib_decode_ctrl
    import fib_cac_pkg::*;
#(
    parameter int unsigned CW_WIDTH   = CW_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CW_WIDTH-1:0]   cw_in,
    input  logic                  cw_valid_in,
    output logic                  cw_ready_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  err_out,
    output logic                  data_valid_out,
    input  logic                  data_ready_in,
    output logic                  busy_out
);

    localparam int unsigned K_W = (CW_WIDTH > 1) ? $clog2(CW_WIDTH) : 1;
    localparam int unsigned WW  = DATA_WIDTH + 1;

    state_t                state;
    logic [CW_WIDTH-1:0]   cw_reg;
    logic [K_W-1:0]        k;
    logic [DATA_WIDTH-1:0] acc;
    logic                  err;
    logic                  prev_bit;
    logic [WW-1:0]         w_cur;
    logic [WW-1:0]         w_prev;

    logic [WW-1:0]         w_cur_nx;
    logic [WW-1:0]         w_prev_nx;
    logic [DATA_WIDTH-1:0] acc_nx;
    logic                  err_nx;
    logic                  last_bit;

    assign last_bit = (k == K_W'(CW_WIDTH - 1));

    fib_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .bit_k     (cw_reg[k]),
        .bit_prev  (prev_bit),
        .w_cur     (w_cur),
        .w_prev    (w_prev),
        .acc       (acc),
        .err       (err),
        .w_cur_nx  (w_cur_nx),
        .w_prev_nx (w_prev_nx),
        .acc_nx    (acc_nx),
        .err_nx    (err_nx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            cw_reg         <= '0;
            k              <= '0;
            acc            <= '0;
            err            <= 1'b0;
            prev_bit       <= 1'b0;
            w_cur          <= WW'(W_INIT);
            w_prev         <= WW'(W_INIT);
            cw_ready_out   <= 1'b1;
            busy_out       <= 1'b0;
            data_valid_out <= 1'b0;
            data_out       <= '0;
            err_out        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cw_valid_in && cw_ready_out) begin
                        cw_reg       <= cw_in;
                        k            <= '0;
                        acc          <= '0;
                        err          <= 1'b0;
                        prev_bit     <= 1'b0;
                        w_cur        <= WW'(W_INIT);
                        w_prev       <= WW'(W_INIT);
                        cw_ready_out <= 1'b0;
                        busy_out     <= 1'b1;
                        state        <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc      <= acc_nx;
                    err      <= err_nx;
                    w_cur    <= w_cur_nx;
                    w_prev   <= w_prev_nx;
                    prev_bit <= cw_reg[k];
                    k        <= k + K_W'(1);
                    // Result registers load from the step outputs so DONE needs no extra cycle.
                    if (last_bit) begin
                        data_out       <= acc_nx;
                        err_out        <= err_nx;
                        data_valid_out <= 1'b1;
                        state          <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (data_ready_in) begin
                        data_valid_out <= 1'b0;
                        busy_out       <= 1'b0;
                        cw_ready_out   <= 1'b1;
                        state          <= ST_IDLE;
                    end
                end
                default: begin
                    data_valid_out <= 1'b0;
                    busy_out       <= 1'b0;
                    cw_ready_out   <= 1'b1;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_decode_ctrl.sv
// Directed bench for fib_decode_ctrl: hand-computed Fibonacci sums, handshake timing, reset abort.
module tb_fib_decode_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cw_in;
    logic       cw_valid_in;
    logic       cw_ready_out;
    logic [5:0] data_out;
    logic       err_out;
    logic       data_valid_out;
    logic       data_ready_in;
    logic       busy_out;

    int checks = 0;
    int errors = 0;

    fib_decode_ctrl #(
        .CW_WIDTH   (8),
        .DATA_WIDTH (6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cw_in          (cw_in),
        .cw_valid_in    (cw_valid_in),
        .cw_ready_out   (cw_ready_out),
        .data_out       (data_out),
        .err_out        (err_out),
        .data_valid_out (data_valid_out),
        .data_ready_in  (data_ready_in),
        .busy_out       (busy_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Accept one codeword from IDLE and follow it through exactly 8 RUN cycles into DONE.
    task automatic run_cw(input string tag, input logic [7:0] cw,
                          input logic [5:0] exp_d, input logic exp_e);
        @(negedge clk);
        cw_in       = cw;
        cw_valid_in = 1'b1;
        @(negedge clk);
        cw_valid_in = 1'b0;
        cw_in       = 8'hFF;
        check({tag, "_busy"}, 32'(busy_out), 32'd1);
        check({tag, "_rdy_run"}, 32'(cw_ready_out), 32'd0);
        repeat (7) @(negedge clk);
        check({tag, "_valid_early"}, 32'(data_valid_out), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(data_valid_out), 32'd1);
        check({tag, "_data"}, 32'(data_out), 32'(exp_d));
        check({tag, "_err"}, 32'(err_out), 32'(exp_e));
    endtask

    task automatic release_done(input string tag);
        data_ready_in = 1'b1;
        @(negedge clk);
        data_ready_in = 1'b0;
        check({tag, "_valid_clr"}, 32'(data_valid_out), 32'd0);
        check({tag, "_rdy_idle"}, 32'(cw_ready_out), 32'd1);
    endtask

    initial begin
        int acc_idx[$];
        int valid_seen;

        rst           = 1'b1;
        cw_in         = '0;
        cw_valid_in   = 1'b0;
        data_ready_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(data_valid_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_err", 32'(err_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", 32'(cw_ready_out), 32'd1);

        run_cw("zero", 8'b00000000, 6'd0, 1'b0);
        release_done("zero");

        run_cw("alt", 8'b10101010, 6'd54, 1'b0);
        release_done("alt");

        run_cw("five", 8'b00000101, 6'd4, 1'b0);
        release_done("five");

        run_cw("adj", 8'b00000011, 6'd1, 1'b1);
        // Stall in DONE: result and handshake must stay frozen.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(data_valid_out), 32'd1);
            check("stall_data", 32'(data_out), 32'd1);
            check("stall_err", 32'(err_out), 32'd1);
            check("stall_rdy", 32'(cw_ready_out), 32'd0);
        end
        release_done("adj");

        // Reset three cycles into RUN discards the codeword.
        @(negedge clk);
        cw_in       = 8'b00101001;
        cw_valid_in = 1'b1;
        @(negedge clk);
        cw_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy_out), 32'd0);
        check("abort_valid", 32'(data_valid_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        valid_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (data_valid_out) valid_seen++;
        end
        check("abort_no_output", 32'(valid_seen), 32'd0);
        check("abort_rdy", 32'(cw_ready_out), 32'd1);

        run_cw("bit6", 8'b01000000, 6'd21, 1'b0);
        release_done("bit6");

        // Back-to-back with valid and ready held high: accept every 10 cycles.
        @(negedge clk);
        cw_in         = 8'b00000101;
        cw_valid_in   = 1'b1;
        data_ready_in = 1'b1;
        for (int i = 0; i < 35; i++) begin
            if (cw_ready_out) acc_idx.push_back(i);
            if (data_valid_out) check("b2b_data", 32'(data_out), 32'd4);
            @(negedge clk);
        end
        cw_valid_in = 1'b0;
        check("b2b_accepts", 32'(acc_idx.size()), 32'd4);
        for (int i = 1; i < acc_idx.size(); i++) begin
            check("b2b_period", 32'(acc_idx[i] - acc_idx[i-1]), 32'd10);
        end
        repeat (12) @(negedge clk);
        data_ready_in = 1'b0;
        check("drain_rdy", 32'(cw_ready_out), 32'd1);
        check("drain_busy", 32'(busy_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
